// File: rtl/exc_handler_if.sv
// Exception handler bus: CSR, pipeline control, host port and scheduler signals.
interface exc_handler_if;
   localparam int unsigned CAUSE_W = 6;
   localparam int unsigned THR_W   = 8;
   localparam int unsigned CNT_W   = 16;

   logic               csr_stall;
   logic [CAUSE_W-1:0] ex_cause;
   logic [THR_W-1:0]   cause_thr;
   logic               pipe_empty;
   logic               host_ack;
   logic               host_resume;

   logic               pipe_flush;
   logic               host_req;
   logic [CAUSE_W-1:0] host_cause;
   logic [THR_W-1:0]   host_thr;
   logic               thr_kill;
   logic [THR_W-1:0]   thr_kill_id;
   logic               clr_ex;
   logic [CNT_W-1:0]   exc_count;
   logic               drain_err;

   // Handler side
   modport slave (
      input  csr_stall, ex_cause, cause_thr, pipe_empty, host_ack, host_resume,
      output pipe_flush, host_req, host_cause, host_thr, thr_kill, thr_kill_id,
             clr_ex, exc_count, drain_err
   );

   // Environment side (CSR, pipeline, host, scheduler)
   modport master (
      output csr_stall, ex_cause, cause_thr, pipe_empty, host_ack, host_resume,
      input  pipe_flush, host_req, host_cause, host_thr, thr_kill, thr_kill_id,
             clr_ex, exc_count, drain_err
   );
endinterface

// File: rtl/exc_handler.sv
// Trap controller: drains the pipeline on a CSR exception, reports it to the
// host, resumes or kills the offending thread and releases the CSR stall.
module exc_handler #(
   parameter int unsigned DRAIN_TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   exc_handler_if.slave bus
);
   localparam int unsigned CAUSE_W = 6;
   localparam int unsigned THR_W   = 8;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned DRAIN_W = 8;

   localparam logic [CAUSE_W-1:0] CAUSE_ALU = 6'h01;
   localparam logic [CAUSE_W-1:0] CAUSE_BRK = 6'h3F;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_REPORT,
      ST_KILL,
      ST_CLEAR,
      ST_WAIT
   } state_e;

   state_e             state_q, state_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [THR_W-1:0]   thr_q, thr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic               derr_q, derr_d;
   logic               flush_q, flush_d;
   logic               req_q, req_d;
   logic               kill_q, kill_d;
   logic               clr_q, clr_d;

   // Next-state, latch and registered-output decode
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      thr_d   = thr_q;
      count_d = count_q;
      drain_d = drain_q;
      derr_d  = derr_q;

      unique case (state_q)
         ST_IDLE: begin
            drain_d = '0;
            if (bus.csr_stall) begin
               state_d = ST_FLUSH;
               cause_d = bus.ex_cause;
               thr_d   = bus.cause_thr;
               if (count_q != '1) count_d = count_q + CNT_W'(1);
            end
         end
         ST_FLUSH: begin
            if (bus.pipe_empty || (drain_q == DRAIN_LAST)) begin
               if (!bus.pipe_empty) derr_d = 1'b1;
               state_d = (cause_q == CAUSE_ALU) ? ST_CLEAR : ST_REPORT;
            end else begin
               drain_d = drain_q + DRAIN_W'(1);
            end
         end
         ST_REPORT: begin
            if (bus.host_ack) begin
               state_d = ((cause_q == CAUSE_BRK) && bus.host_resume) ? ST_CLEAR : ST_KILL;
            end
         end
         ST_KILL:  state_d = ST_CLEAR;
         ST_CLEAR: state_d = ST_WAIT;
         ST_WAIT: begin
            if (!bus.csr_stall) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase

      flush_d = (state_d == ST_FLUSH);
      req_d   = (state_d == ST_REPORT);
      kill_d  = (state_d == ST_KILL);
      clr_d   = (state_d == ST_CLEAR);
   end

   // State, latches and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cause_q <= '0;
         thr_q   <= '0;
         count_q <= '0;
         drain_q <= '0;
         derr_q  <= 1'b0;
         flush_q <= 1'b0;
         req_q   <= 1'b0;
         kill_q  <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         thr_q   <= thr_d;
         count_q <= count_d;
         drain_q <= drain_d;
         derr_q  <= derr_d;
         flush_q <= flush_d;
         req_q   <= req_d;
         kill_q  <= kill_d;
         clr_q   <= clr_d;
      end
   end

   assign bus.pipe_flush  = flush_q;
   assign bus.host_req    = req_q;
   assign bus.host_cause  = cause_q;
   assign bus.host_thr    = thr_q;
   assign bus.thr_kill    = kill_q;
   assign bus.thr_kill_id = thr_q;
   assign bus.clr_ex      = clr_q;
   assign bus.exc_count   = count_q;
   assign bus.drain_err   = derr_q;
endmodule

// File: tb/tb_exc_handler.sv
// Scoreboard bench for exc_handler: a driver plays CSR, pipeline and host,
// pushing the expected outcome of each exception; a monitor pops on clr_ex.
module tb_exc_handler;
   localparam int unsigned DT = 16;

   typedef struct {
      logic [5:0]  cause;
      logic [7:0]  thr;
      int          fl;
      int          rq;
      int          kl;
      logic [15:0] cnt;
      logic        derr;
   } exp_t;

   logic clk;
   logic rst_n;
   exc_handler_if ifc ();

   exc_handler #(.DRAIN_TIMEOUT(DT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];
   int   m_cnt = 0;
   bit   m_derr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flush"}, 32'(ifc.pipe_flush), 0);
      chk({tag, "_req"},   32'(ifc.host_req), 0);
      chk({tag, "_cause"}, 32'(ifc.host_cause), 0);
      chk({tag, "_thr"},   32'(ifc.host_thr), 0);
      chk({tag, "_kill"},  32'(ifc.thr_kill), 0);
      chk({tag, "_kid"},   32'(ifc.thr_kill_id), 0);
      chk({tag, "_clr"},   32'(ifc.clr_ex), 0);
      chk({tag, "_cnt"},   32'(ifc.exc_count), 0);
      chk({tag, "_derr"},  32'(ifc.drain_err), 0);
   endtask

   // One exception: e = FLUSH cycles with pipe_empty low, a = REPORT cycles
   // before host_ack, r = host_resume at ack, hold = extra WAIT cycles.
   task automatic run_exc(input logic [5:0] c, input logic [7:0] t, input int unsigned e,
                          input int a, input bit r, input int hold);
      exp_t x;
      int   fl, rq, guard;
      bit   done;
      x.cause = c;
      x.thr   = t;
      x.fl    = (e + 1 < DT) ? int'(e + 1) : int'(DT);
      m_derr  = m_derr | (e >= DT);
      x.derr  = m_derr;
      x.rq    = (c == 6'h01) ? 0 : a;
      x.kl    = ((c != 6'h01) && !((c == 6'h3F) && r)) ? 1 : 0;
      m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      x.cnt   = 16'(m_cnt);
      sb_q.push_back(x);

      @(negedge clk);
      ifc.csr_stall  = 1'b1;
      ifc.ex_cause   = c;
      ifc.cause_thr  = t;
      ifc.pipe_empty = (e == 0);
      ifc.host_ack   = 1'b0;
      fl = 0; rq = 0; guard = 0; done = 1'b0;
      while (!done && guard < 400) begin
         @(negedge clk);
         guard++;
         ifc.ex_cause  = 6'($urandom);
         ifc.cause_thr = 8'($urandom);
         if (ifc.pipe_flush) begin
            fl++;
            ifc.pipe_empty = (fl > int'(e));
         end else begin
            ifc.pipe_empty = 1'($urandom);
         end
         if (ifc.host_req) begin
            rq++;
            ifc.host_ack    = (rq == a);
            ifc.host_resume = (rq == a) ? r : 1'($urandom);
         end else begin
            ifc.host_ack    = ($urandom_range(0, 3) == 0);
            ifc.host_resume = 1'($urandom);
         end
         if (ifc.clr_ex) begin
            repeat (hold) @(negedge clk);
            ifc.csr_stall = 1'b0;
            @(negedge clk);
            done = 1'b1;
         end
      end
      ifc.host_ack = 1'b0;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drv_timeout: cause %0h thr %0h got no clr_ex within 400 cycles", c, t);
      end
   endtask

   // Monitor: accumulate per-exception observations, score on clr_ex
   initial begin
      int   fl, rq, kl, viol;
      logic [7:0] kid;
      bit   stall_seen;
      exp_t x;
      fl = 0; rq = 0; kl = 0; viol = 0; kid = '0; stall_seen = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            fl = 0; rq = 0; kl = 0; viol = 0; stall_seen = 1'b0;
         end else begin
            if (ifc.csr_stall && !stall_seen) begin
               stall_seen = 1'b1;
               chk("stall_to_flush", 32'(ifc.pipe_flush), 1);
            end
            if (!ifc.csr_stall) stall_seen = 1'b0;
            if (ifc.pipe_flush) fl++;
            if (ifc.host_req) begin
               rq++;
               if (sb_q.size() > 0 &&
                   (ifc.host_cause !== sb_q[0].cause || ifc.host_thr !== sb_q[0].thr))
                  viol++;
            end
            if (ifc.thr_kill) begin
               kl++;
               kid = ifc.thr_kill_id;
            end
            if (ifc.clr_ex) begin
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_clr: clr_ex with empty scoreboard at %0t", $time);
               end else begin
                  x = sb_q.pop_front();
                  chk("flush_cycles", 32'(fl), 32'(x.fl));
                  chk("req_cycles",   32'(rq), 32'(x.rq));
                  chk("kill_pulses",  32'(kl), 32'(x.kl));
                  if (x.kl == 1) chk("kill_id", 32'(kid), 32'(x.thr));
                  chk("host_cause",   32'(ifc.host_cause), 32'(x.cause));
                  chk("host_thr",     32'(ifc.host_thr), 32'(x.thr));
                  chk("req_stable",   32'(viol), 0);
                  chk("exc_count",    32'(ifc.exc_count), 32'(x.cnt));
                  chk("drain_err",    32'(ifc.drain_err), 32'(x.derr));
               end
               fl = 0; rq = 0; kl = 0; viol = 0;
            end
         end
      end
   end

   // Stimulus
   initial begin
      int unsigned e;
      logic [5:0]  c;
      int          guard;
      rst_n           = 1'b0;
      ifc.csr_stall   = 1'b0;
      ifc.ex_cause    = '0;
      ifc.cause_thr   = '0;
      ifc.pipe_empty  = 1'b0;
      ifc.host_ack    = 1'b0;
      ifc.host_resume = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_all_zero("post_rst");

      // Directed: ALU, breakpoint resume, fatal despite resume, drain timeout
      run_exc(6'h01, 8'h07, 0, 1, 1'b0, 0);
      run_exc(6'h3F, 8'h22, 0, 5, 1'b1, 0);
      run_exc(6'h12, 8'h05, 0, 2, 1'b1, 0);
      run_exc(6'h3F, 8'h40, 20, 1, 1'b1, 0);
      run_exc(6'h01, 8'h41, 0, 1, 1'b0, 0);
      run_exc(6'h05, 8'h42, DT - 1, 1, 1'b0, 1);
      run_exc(6'h3F, 8'h43, 2, 3, 1'b0, 2);

      // Random mix of causes, drain lengths, ack delays and WAIT holds
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0:       c = 6'h01;
            1:       c = 6'h05;
            2:       c = 6'h0B;
            3:       c = 6'h12;
            4:       c = 6'h3F;
            default: c = 6'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) e = $urandom_range(DT - 2, DT + 2);
         else                           e = $urandom_range(0, 4);
         run_exc(c, 8'($urandom), e, $urandom_range(1, 6), 1'($urandom), $urandom_range(0, 2));
      end

      // Latched cause/thread frozen in REPORT, then reset mid-operation
      @(negedge clk);
      ifc.csr_stall  = 1'b1;
      ifc.ex_cause   = 6'h3F;
      ifc.cause_thr  = 8'h5A;
      ifc.pipe_empty = 1'b1;
      guard = 0;
      while (!ifc.host_req && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      ifc.ex_cause  = 6'h01;
      ifc.cause_thr = 8'h99;
      repeat (3) @(negedge clk);
      chk("midop_req",   32'(ifc.host_req), 1);
      chk("midop_cause", 32'(ifc.host_cause), 32'h3F);
      chk("midop_thr",   32'(ifc.host_thr), 32'h5A);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midop_rst");
      ifc.csr_stall = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      m_cnt  = 0;
      m_derr = 1'b0;
      @(negedge clk);
      chk_all_zero("midop_post");

      run_exc(6'h01, 8'h11, 0, 1, 1'b0, 0);

      // Counter saturation: preload near the top while idle
      @(negedge clk);
      force dut.count_q = 16'hFFFC;
      @(negedge clk);
      release dut.count_q;
      m_cnt = 16'hFFFC;
      for (int i = 0; i < 5; i++) run_exc(6'h01, 8'(i), 0, 1, 1'b0, 0);
      run_exc(6'h0B, 8'h33, 1, 2, 1'b1, 0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
